// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, canonical NOP and
// the fetch-queue entry layout.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } ifq_entry_t;

endpackage : riscv_pkg

// File: rtl/if_id_fetch_queue_if.sv
// Fetch/decode handshake bundle. The master side is the pipeline around the
// queue (IF stage producing, ID stage consuming); the slave side is the queue.
interface if_id_fetch_queue_if;
  import riscv_pkg::*;

  // fetch side
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_instr;
  logic            stallF;

  // decode side
  logic            stallD;
  logic            flushD;
  logic            validD;
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;

  modport master (
    output fetch_valid, fetch_pc, fetch_instr, stallD, flushD,
    input  stallF, validD, InstrD, PCD, PCPlus4D
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_instr, stallD, flushD,
    output stallF, validD, InstrD, PCD, PCPlus4D
  );

endinterface : if_id_fetch_queue_if

// File: rtl/if_id_fetch_queue_fifo_ctrl.sv
// Pointer/occupancy controller for the fetch queue. Decides when an entry is
// accepted or retired; the storage itself lives in the top.
module fifo_ctrl #(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic             stall,
  input  logic             flush,
  output logic             enq,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count;
  logic             deq;

  // Full/empty come from registered count only, so stallF has no path from
  // stallD and a full queue refuses a fetch even if decode retires that cycle.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign enq   = fetch_valid & ~full & ~flush;
  assign deq   = ~empty & ~stall & ~flush;

  // Pointer and occupancy update; reset beats flush, flush beats enq/deq.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : fifo_ctrl

// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: captures {PC, instr, PC+4} from fetch and presents the
// oldest entry to decode. Back-pressures the PC register when full.
module if_id_fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic                 clk,
  input logic                 reset,
  if_id_fetch_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             enq;
  logic             full;
  logic             empty;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  ifq_entry_t entries [DEPTH];
  ifq_entry_t head;

  fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (bus.fetch_valid),
    .stall       (bus.stallD),
    .flush       (bus.flushD),
    .enq         (enq),
    .full        (full),
    .empty       (empty),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr)
  );

  // Capture the fetched pair with its fall-through PC (wraps modulo 2^XLEN).
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the empty flag masks stale
    // contents, and leaving it unreset lets it map to plain RAM/flops.
    if (enq) begin
      entries[wr_ptr] <= '{pc:       bus.fetch_pc,
                           instr:    bus.fetch_instr,
                           pc_plus4: bus.fetch_pc + XLEN'(4)};
    end
  end

  assign head       = entries[rd_ptr];
  assign bus.stallF = full;
  assign bus.validD = ~empty;

  // Decode view of the head entry; an empty queue shows a harmless NOP.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    bus.InstrD   = NOP_INSTR;
    bus.PCD      = '0;
    bus.PCPlus4D = '0;
    if (!empty) begin
      bus.InstrD   = head.instr;
      bus.PCD      = head.pc;
      bus.PCPlus4D = head.pc_plus4;
    end
  end

endmodule : if_id_fetch_queue
